// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encodings,
// the pattern itself and the state register width.
package seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } stateT;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    assign sat = (q == {W{1'b1}});

    // Clear outranks an increment arriving on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Moore FSM detecting the serial pattern 1011 (MSB first), with a registered
// one-cycle detect pulse and a saturating match counter.
module seq_detector
    import seq_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               X,
    input  logic               en,
    input  logic               clr,
    output logic               Y,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   count,
    output logic               sat
);

    stateT stateReg;
    stateT stateNext;
    logic  matchSet;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= S0;
        end else begin
            stateReg <= stateNext;
        end
    end

    // matchSet is only raised by an accepted completing bit, so sitting in S4
    // with en low never re-fires the pulse or the counter.
    always_comb begin
        stateNext = stateReg;
        matchSet  = 1'b0;
        case (stateReg)
            S0: if (en) stateNext = (X == PATTERN[3]) ? S1 : S0;
            S1: if (en) stateNext = (X == PATTERN[2]) ? S2 : S1;
            S2: if (en) stateNext = (X == PATTERN[1]) ? S3 : S0;
            S3: begin
                if (en) begin
                    stateNext = (X == PATTERN[0]) ? S4 : S2;
                    matchSet  = (X == PATTERN[0]);
                end
            end
            S4: begin
                if (en) begin
                    stateNext = (X == PATTERN[3]) ? S1 : ((OVERLAP != 0) ? S2 : S0);
                end
            end
            default: stateNext = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Y <= 1'b0;
        end else begin
            Y <= matchSet;
        end
    end

    assign state = stateReg;

    sat_counter #(
        .W(CNT_W)
    ) matchCounter (
        .clk (clk),
        .rst (rst),
        .inc (matchSet),
        .clr (clr),
        .q   (count),
        .sat (sat)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: an overlapping 2-bit-counter instance and a
// non-overlapping 8-bit-counter instance share one stimulus stream.
module tb_seq_detector;
    import seq_pkg::*;

    localparam int PAT = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       X   = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;

    logic       YA, YB;
    logic [2:0] stateA, stateB;
    logic [1:0] countA;
    logic [7:0] countB;
    logic       satA, satB;

    int nChecks = 0;
    int nPass   = 0;

    always #10 clk = ~clk;

    seq_detector #(.OVERLAP(1), .CNT_W(2)) dutA (
        .clk(clk), .rst(rst), .X(X), .en(en), .clr(clr),
        .Y(YA), .state(stateA), .count(countA), .sat(satA)
    );

    seq_detector #(.OVERLAP(0), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .X(X), .en(en), .clr(clr),
        .Y(YB), .state(stateB), .count(countB), .sat(satB)
    );

    typedef struct packed {
        logic       yA;
        logic [2:0] stA;
        logic [7:0] cntA;
        logic       satA;
        logic       yB;
        logic [2:0] stB;
        logic [7:0] cntB;
        logic       satB;
    } expT;

    expT sbQ[$];

    // Reference model: a sliding window of the last accepted bits; the state is
    // the longest window suffix that is a prefix of the pattern.
    int unsigned winBits[2];
    int          winLen[2];
    int          mState[2];
    int          mCount[2];
    int          mY[2];
    int          mMax[2]     = '{3, 255};
    int          mOverlap[2] = '{1, 0};

    function automatic int prefixLen(int unsigned bits, int len);
        for (int k = (len < 4 ? len : 4); k >= 1; k--) begin
            if ((bits & ((32'd1 << k) - 1)) == (PAT >> (4 - k))) return k;
        end
        return 0;
    endfunction

    task automatic modelReset(int d);
        winBits[d] = 0;
        winLen[d]  = 0;
        mState[d]  = 0;
        mCount[d]  = 0;
        mY[d]      = 0;
    endtask

    task automatic modelStep(int d, bit x, bit enV, bit clrV);
        int k;
        mY[d] = 0;
        if (enV) begin
            winBits[d] = ((winBits[d] << 1) | x) & 15;
            if (winLen[d] < 4) winLen[d]++;
            k = prefixLen(winBits[d], winLen[d]);
            mState[d] = k;
            if (k == 4) begin
                mY[d] = 1;
                if (mCount[d] < mMax[d]) mCount[d]++;
                if (mOverlap[d] == 0) begin
                    winBits[d] = 0;
                    winLen[d]  = 0;
                end
            end
        end
        if (clrV) mCount[d] = 0;
    endtask

    task automatic pushExpected();
        expT e;
        e.yA   = mY[0][0];
        e.stA  = 3'(mState[0]);
        e.cntA = 8'(mCount[0]);
        e.satA = (mCount[0] == mMax[0]);
        e.yB   = mY[1][0];
        e.stB  = 3'(mState[1]);
        e.cntB = 8'(mCount[1]);
        e.satB = (mCount[1] == mMax[1]);
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(string name, int act, int exp);
        nChecks++;
        if (act == exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(bit x, bit enV, bit clrV);
        @(negedge clk);
        X   = x;
        en  = enV;
        clr = clrV;
        modelStep(0, x, enV, clrV);
        modelStep(1, x, enV, clrV);
        pushExpected();
    endtask

    task automatic applyBits(logic [15:0] bits, int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i], 1'b1, 1'b0);
    endtask

    // Low pulse of 5 ns between edges; outputs are sampled while still in reset.
    task automatic resetPulse();
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rstStateA", stateA, 0);
        checkOutput("rstYA", YA, 0);
        checkOutput("rstCountA", countA, 0);
        checkOutput("rstSatA", satA, 0);
        checkOutput("rstStateB", stateB, 0);
        checkOutput("rstCountB", countB, 0);
        #4 rst = 1'b1;
        modelReset(0);
        modelReset(1);
        pushExpected();
    endtask

    always @(posedge clk) begin
        expT e;
        #1;
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("YA", YA, e.yA);
            checkOutput("stateA", stateA, e.stA);
            checkOutput("countA", countA, e.cntA);
            checkOutput("satA", satA, e.satA);
            checkOutput("YB", YB, e.yB);
            checkOutput("stateB", stateB, e.stB);
            checkOutput("countB", countB, e.cntB);
            checkOutput("satB", satB, e.satB);
        end
    end

    initial begin
        int waitCycles;

        resetPulse();

        // Overlapping vs restarting detection on 1011011.
        applyBits(16'b1011011, 7);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Partial match discarded by reset, then a fresh 1.
        applyBits(16'b101, 3);
        resetPulse();
        applyStimulus(1'b1, 1'b1, 1'b0);

        // en low with X toggling holds the partial match.
        applyBits(16'b101, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Saturation of the 2-bit counter, then clear.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyBits(16'b1011, 4);
        for (int i = 0; i < 4; i++) applyBits(16'b011, 3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Clear coinciding with a completing bit.
        applyBits(16'b101, 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Illegal encoding recovers to S0 even with en low.
        resetPulse();
        @(negedge clk);
        force dutA.stateReg = stateT'(3'b111);
        #1 release dutA.stateReg;
        X   = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        modelStep(1, 1'b1, 1'b0, 1'b0);
        mState[0]  = 0;
        mY[0]      = 0;
        winBits[0] = 0;
        winLen[0]  = 0;
        pushExpected();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 24) == 0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        waitCycles = 0;
        while (sbQ.size() != 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        checkOutput("drain", sbQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = detector restarts after each match.
REQ-002 SHALL have parameter CNT_W, default 8; width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port X, input, 1 bit; serial data bit, the stream produced by the sequence generator output Y.
REQ-006 SHALL have port en, input, 1 bit; X is accepted on a rising clk edge only when en=1.
REQ-007 SHALL have port clr, input, 1 bit; synchronous clear of the match counter and sat.
REQ-008 SHALL have port Y, output, 1 bit; registered detect pulse.
REQ-009 SHALL have port state, output, 3 bits; current FSM state encoding.
REQ-010 SHALL have port count, output, CNT_W bits; saturating number of matches.
REQ-011 SHALL have port sat, output, 1 bit; high while count is at its maximum value.

Function
REQ-012 SHALL detect the serial pattern 1011, with the first received bit being the MSB.
REQ-013 SHALL implement a Moore FSM with states S0=000 (nothing matched), S1=001 ("1"), S2=010 ("10"), S3=011 ("101") and S4=100 ("1011" found).
REQ-014 Transitions on an accepted bit SHALL be: S0: 1->S1, 0->S0; S1: 1->S1, 0->S2; S2: 1->S3, 0->S0; S3: 1->S4, 0->S2.
REQ-015 From S4 with OVERLAP=1, transitions SHALL be 1->S1 and 0->S2.
REQ-016 From S4 with OVERLAP=0, transitions SHALL be 1->S1 and 0->S0.
REQ-017 When en=0, state SHALL hold, Y SHALL be 0 and count SHALL hold; X is ignored.
REQ-018 Y SHALL be 1 for exactly one clk cycle, in the cycle after the edge that accepts the completing bit (the edge at which the next state is S4); Y SHALL be 0 otherwise.
REQ-019 Y SHALL NOT re-assert while the FSM sits in S4 with en=0.
REQ-020 On each edge at which Y is set, count SHALL increment by 1, with latency equal to Y's.
REQ-021 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 sat SHALL equal 1 exactly when count = 2^CNT_W-1.
REQ-023 clr=1 SHALL set count to 0 and sat to 0 on the next edge, and SHALL NOT affect state or Y.
REQ-024 When clr coincides with a completing match, clr SHALL win: count=0 and Y=1.
REQ-025 Illegal state encodings (101, 110, 111) SHALL go to S0 on the next edge, regardless of en.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for clk, force state=S0, Y=0, count=0 and sat=0.
REQ-027 Reset asserted mid-pattern SHALL discard the partial match; detection SHALL restart from S0 after rst=1.
REQ-028 The first accepted bit SHALL be the first rising clk edge with rst=1 and en=1.

Structure
REQ-029 A shared package seq_pkg SHALL hold the state encodings S0..S4, the PATTERN constant 4'b1011 and the state width 3.
REQ-030 The match counter SHALL be a sub-module sat_counter (parameter W; ports clk, rst, inc, clr, q, sat) instantiated once.
REQ-031 The FSM next-state logic, state register and Y register SHALL reside in seq_detector.

Verification
REQ-032 OVERLAP=1, en=1, X = 1,0,1,1,0,1,1 on consecutive edges -> Y pulses after bit 4 and after bit 7; count=2.
REQ-033 OVERLAP=0, same stream as REQ-032 -> one Y pulse, after bit 4; count=1; final state=S1.
REQ-034 X = 1,0,1, then rst=0 for 5 ns between edges, then rst=1 and X = 1 -> no Y pulse; state=S1 after the X=1 edge.
REQ-035 X = 1,0,1, then en=0 for 3 cycles with X toggling, then en=1 and X=1 -> state holds S3 during the en=0 cycles; a single Y pulse follows the final bit.
REQ-036 CNT_W=2, OVERLAP=1, stream 1011 followed by "011" repeated 4 times (5 matches) -> count stays 3, sat=1 after the third match; then clr=1 -> count=0, sat=0.
REQ-037 Bench SHALL force state to 111 and apply one edge -> state=S0, Y=0.
